mod_sub_seq: RTL and testbench

Sequential multi-limb modular subtractor for the ECC datapath: computes r = (a − b) mod p over W = 64·LIMBS bits, processing one 64-bit limb per cycle with a single shared subtract/add lane. It is the inverse-direction counterpart to the field modular adder and is used by the point add/double sequencer wherever a field subtraction is needed. Operands and modulus are latched on start; the result is held until the next accepted start.

---
 rtl/mod_sub_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_mod_sub_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mod_sub_seq.sv
// Sequential multi-limb modular subtractor: r = (a - b) mod p, one 64-bit limb per cycle.
// Optional MODSUB_ZERO_FLAG_EN adds a registered is_zero flag that is valid with done.
module mod_sub_seq #(
    parameter int LIMBS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [64*LIMBS-1:0]   a,
    input  logic [64*LIMBS-1:0]   b,
    input  logic [64*LIMBS-1:0]   p,
    output logic                  ready,
    output logic                  done,
    output logic [64*LIMBS-1:0]   r
`ifdef MODSUB_ZERO_FLAG_EN
    ,
    output logic                  is_zero
`endif
);

    localparam int W  = 64 * LIMBS;
    localparam int IW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(LIMBS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_CORR = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Shared lane: subtraction is x + ~y + ~borrow, carry-out inverted gives borrow-out.
    function automatic logic [64:0] lane_add(input logic [63:0] x,
                                             input logic [63:0] y,
                                             input logic        cin);
        lane_add = {1'b0, x} + {1'b0, y} + {64'd0, cin};
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    p_r;
    logic [W-1:0]    r_r;
    logic [IW-1:0]   idx_r;
    logic [IW-1:0]   idx_nxt_s;
    logic [IW+5:0]   base_s;
    logic            bc_r;
    logic            ready_r;
    logic            done_r;
    logic            accept_s;
    logic            last_s;
    logic [63:0]     x_limb_s;
    logic [63:0]     y_limb_s;
    logic            cin_s;
    logic [64:0]     lane_s;
    logic [63:0]     sum_s;
    logic            cout_s;
    logic            borrow_s;
`ifdef MODSUB_ZERO_FLAG_EN
    logic            nz_r;
    logic            nz_nxt_s;
    logic            is_zero_r;
`endif

    assign base_s = {idx_r, 6'd0};
    assign ready  = ready_r;
    assign done   = done_r;
    assign r      = r_r;
`ifdef MODSUB_ZERO_FLAG_EN
    assign is_zero = is_zero_r;
`endif

    // Operand selection for the single add/subtract lane.
    always_comb begin
        x_limb_s = 64'd0;
        y_limb_s = 64'd0;
        cin_s    = 1'b0;
        case (state_r)
            ST_SUB: begin
                x_limb_s = a_r[base_s +: 64];
                y_limb_s = ~b_r[base_s +: 64];
                cin_s    = ~bc_r;
            end
            ST_CORR: begin
                x_limb_s = r_r[base_s +: 64];
                y_limb_s = p_r[base_s +: 64];
                cin_s    = bc_r;
            end
            default: begin
                x_limb_s = 64'd0;
                y_limb_s = 64'd0;
                cin_s    = 1'b0;
            end
        endcase
        lane_s   = lane_add(x_limb_s, y_limb_s, cin_s);
        sum_s    = lane_s[63:0];
        cout_s   = lane_s[64];
        borrow_s = ~lane_s[64];
    end

    // Next-state and sequencing controls.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        last_s      = (idx_r == LAST_IDX);
        if (last_s) begin
            idx_nxt_s = {IW{1'b0}};
        end else begin
            idx_nxt_s = idx_r + IW'(1);
        end
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_SUB;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SUB: begin
                if (last_s) begin
                    if (borrow_s) begin
                        state_nxt_s = ST_CORR;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_SUB;
                end
            end
            ST_CORR: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CORR;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

`ifdef MODSUB_ZERO_FLAG_EN
    // Running OR of limbs written in the current phase; restarts at limb 0.
    always_comb begin
        if (idx_r == {IW{1'b0}}) begin
            nz_nxt_s = |sum_s;
        end else begin
            nz_nxt_s = nz_r | (|sum_s);
        end
    end
`endif

    // State register with registered ready/done decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Operand latch, limb index, borrow/carry chain and result limbs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= {W{1'b0}};
            b_r   <= {W{1'b0}};
            p_r   <= {W{1'b0}};
            r_r   <= {W{1'b0}};
            idx_r <= {IW{1'b0}};
            bc_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r   <= a;
                        b_r   <= b;
                        p_r   <= p;
                        idx_r <= {IW{1'b0}};
                        bc_r  <= 1'b0;
                    end
                end
                ST_SUB: begin
                    r_r[base_s +: 64] <= sum_s;
                    idx_r             <= idx_nxt_s;
                    // The correction phase starts with a clear carry.
                    bc_r              <= last_s ? 1'b0 : borrow_s;
                end
                ST_CORR: begin
                    r_r[base_s +: 64] <= sum_s;
                    idx_r             <= idx_nxt_s;
                    bc_r              <= last_s ? 1'b0 : cout_s;
                end
                default: begin
                    bc_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef MODSUB_ZERO_FLAG_EN
    // Zero flag: cleared on accept, captured as the final phase finishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            nz_r      <= 1'b0;
            is_zero_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        nz_r      <= 1'b0;
                        is_zero_r <= 1'b0;
                    end
                end
                ST_SUB, ST_CORR: begin
                    nz_r <= nz_nxt_s;
                    if (state_nxt_s == ST_DONE) begin
                        is_zero_r <= ~nz_nxt_s;
                    end
                end
                default: begin
                    nz_r <= nz_r;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_mod_sub_seq.sv
// Scoreboard bench for mod_sub_seq: directed vectors queue expected results,
// a negedge monitor compares whenever done pulses.
module tb_mod_sub_seq;

    localparam int LIMBS = 4;
    localparam int W     = 64 * LIMBS;
    localparam logic [W-1:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    logic         ready;
    logic         done;
    logic [W-1:0] r;
`ifdef MODSUB_ZERO_FLAG_EN
    logic         is_zero;
`endif

    mod_sub_seq #(.LIMBS(LIMBS)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .p      (p),
        .ready  (ready),
        .done   (done),
        .r      (r)
`ifdef MODSUB_ZERO_FLAG_EN
        ,
        .is_zero(is_zero)
`endif
    );

    typedef struct {
        logic [W-1:0] er;
        int           lat;
        logic         ez;
        int           icyc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   ready_chk = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Wait for ready, present one operation, optionally queue its expectation.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [W-1:0] er, input int el, input logic ez,
                         input bit push);
        int w;
        w = 0;
        @(negedge clk);
        while (!ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!ready) begin
            chk("issue_ready_timeout", {{(W-1){1'b0}}, ready}, {{(W-1){1'b0}}, 1'b1});
        end
        a     = ta;
        b     = tb;
        p     = P;
        start = 1'b1;
        if (push) sbq.push_back('{er, el, ez, cyc});
        @(negedge clk);
        start = 1'b0;
        a     = {8{$urandom()}};
        b     = {8{$urandom()}};
        p     = {8{$urandom()}};
        chk("busy_ready_low", {{(W-1){1'b0}}, ready}, {W{1'b0}});
    endtask

    // Monitor: pop and compare on each done, then confirm single pulse and ready return.
    always @(negedge clk) begin
        exp_t e;
        if (ready_chk) begin
            chk("ready_after_done", {{(W-1){1'b0}}, ready}, {{(W-1){1'b0}}, 1'b1});
            chk("done_single_pulse", {{(W-1){1'b0}}, done}, {W{1'b0}});
            ready_chk = 1'b0;
        end else if (done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=done_high required=no_done r=%h", r);
            end else begin
                e = sbq.pop_front();
                chk("result_r", r, e.er);
                chk("latency", W'(cyc - e.icyc), W'(e.lat));
`ifdef MODSUB_ZERO_FLAG_EN
                chk("is_zero", {{(W-1){1'b0}}, is_zero}, {{(W-1){1'b0}}, e.ez});
`endif
            end
            ready_chk = 1'b1;
        end
    end

    initial begin
        int w;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        p     = P;
        repeat (3) @(negedge clk);
        chk("reset_ready", {{(W-1){1'b0}}, ready}, {{(W-1){1'b0}}, 1'b1});
        chk("reset_done", {{(W-1){1'b0}}, done}, {W{1'b0}});
        chk("reset_r", r, {W{1'b0}});
`ifdef MODSUB_ZERO_FLAG_EN
        chk("reset_is_zero", {{(W-1){1'b0}}, is_zero}, {W{1'b0}});
`endif
        rst = 1'b0;

        // Basic no-borrow and correction paths.
        issue(256'd5, 256'd3, 256'd2, 5, 1'b0, 1'b1);
        issue(256'd3, 256'd5, P - 256'd2, 9, 1'b0, 1'b1);
        // Borrow ripples across limb boundary.
        issue(256'h1_00000000_00000000, 256'd1, 256'h0_FFFFFFFF_FFFFFFFF, 5, 1'b0, 1'b1);
        // Equal operands give zero without correction.
        issue(256'h12345678_9ABCDEF0_0FEDCBA9_87654321_13579BDF_2468ACE0_DEADBEEF_CAFEF00D,
              256'h12345678_9ABCDEF0_0FEDCBA9_87654321_13579BDF_2468ACE0_DEADBEEF_CAFEF00D,
              256'd0, 5, 1'b1, 1'b1);
        issue(P - 256'd1, 256'd0, P - 256'd1, 5, 1'b0, 1'b1);
        issue(256'd0, P - 256'd1, 256'd1, 9, 1'b0, 1'b1);
        issue(256'h1 << 192, (256'h1 << 192) - 256'd1, 256'd1, 5, 1'b0, 1'b1);
        // Out-of-range operands: unreduced results.
        issue({W{1'b1}}, 256'd0, {W{1'b1}}, 5, 1'b0, 1'b1);
        issue(256'd0, {W{1'b1}}, P + 256'd1, 9, 1'b0, 1'b1);

        // Start pulsed while busy must be ignored.
        issue(256'd100, 256'd1, 256'd99, 5, 1'b0, 1'b1);
        a     = 256'd1;
        b     = 256'd2;
        p     = P;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Back-to-back: second start lands in the cycle ready returns.
        issue(256'd7, 256'd9, P - 256'd2, 9, 1'b0, 1'b1);
        issue(256'd9, 256'd7, 256'd2, 5, 1'b0, 1'b1);

        // Reset in the middle of a correction: op discarded, no done.
        issue(256'd3, 256'd5, 256'd0, 9, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", {{(W-1){1'b0}}, ready}, {{(W-1){1'b0}}, 1'b1});
        chk("midrst_r", r, {W{1'b0}});
        chk("midrst_done", {{(W-1){1'b0}}, done}, {W{1'b0}});
        repeat (12) @(negedge clk);
        issue(256'd10, 256'd4, 256'd6, 5, 1'b0, 1'b1);

        w = 0;
        while (sbq.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0 pending", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
